// File: rtl/commutation_pkg.sv
// commutation_pkg: shared types and constants for the BLDC commutation path.
// Provides the drive-mode enum, per-leg {h,l} struct, pattern type and step LUT.
package commutation_pkg;

    typedef enum logic [1:0] {
        COAST = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2,
        HOLD  = 2'd3
    } mode_e;

    typedef struct packed {
        logic h;
        logic l;
    } leg_t;

    // Bit order {AH,BH,CH,AL,BL,CL}
    typedef logic [5:0] pattern_t;

    localparam pattern_t BRAKE_PATTERN = 6'b000111;

    // Indexed by drive index
    localparam pattern_t STEP_LUT [6] = '{
        6'b001010,  // 0 CH.BL
        6'b100010,  // 1 AH.BL
        6'b100001,  // 2 AH.CL
        6'b010001,  // 3 BH.CL
        6'b010100,  // 4 BH.AL
        6'b001100   // 5 CH.AL
    };

    // Neighbouring step modulo 6
    function automatic logic [2:0] step_wrap(input logic [2:0] s, input logic up);
        if (up) return (s >= 3'd5) ? 3'd0 : s + 3'd1;
        else    return (s == 3'd0) ? 3'd5 : s - 3'd1;
    endfunction

endpackage

// File: rtl/deadtime_leg.sv
// deadtime_leg: one half-bridge leg with dead-time insertion.
// Ports: i_clk, i_rst_n, i_req {h,l} request, i_deadtime, o_leg applied {h,l}.
module deadtime_leg
    import commutation_pkg::*;
#(
    parameter int K_DEADTIME_W = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  leg_t                    i_req,
    input  logic [K_DEADTIME_W-1:0] i_deadtime,
    output leg_t                    o_leg
);

    leg_t                    leg_q;
    leg_t                    leg_d;
    logic [K_DEADTIME_W-1:0] off_cnt_q;
    logic [K_DEADTIME_W-1:0] off_cnt_d;
    logic                    may_on;
    logic                    shoot;

    assign may_on = (off_cnt_q >= i_deadtime);
    // A shoot-through request parks the leg off
    assign shoot  = i_req.h & i_req.l;

    always_comb begin
        leg_d   = '0;
        leg_d.h = i_req.h & ~shoot & (leg_q.h | may_on);
        leg_d.l = i_req.l & ~shoot & (leg_q.l | may_on);
    end

    // Counts cycles the applied leg has been fully off, saturating
    always_comb begin
        off_cnt_d = '0;
        if (leg_q == '0)
            off_cnt_d = (&off_cnt_q) ? off_cnt_q : off_cnt_q + K_DEADTIME_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            leg_q     <= '0;
            off_cnt_q <= '0;
        end else begin
            leg_q     <= leg_d;
            off_cnt_q <= off_cnt_d;
        end
    end

    assign o_leg = leg_q;

endmodule

// File: rtl/commutation_engine.sv
// commutation_engine: six-step BLDC step tracker, pattern select, PWM chop and dead time.
// Ports: i_clk, i_rst_n, i_mode, force/trigger step controls, chop controls, i_deadtime;
// outputs o_pattern {AH,BH,CH,AL,BL,CL}, o_step, o_substep, o_commutate.
// Macro COMMUTATION_ENGINE_DEADTIME_EN enables the per-leg dead-time stage.
module commutation_engine
    import commutation_pkg::*;
#(
    parameter  int K_NSUBSTEPS  = 10,
    parameter  int K_DEADTIME_W = 4,
    localparam int SW           = $clog2(K_NSUBSTEPS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [1:0]              i_mode,
    input  logic                    i_force_step_trigger,
    input  logic [2:0]              i_force_step_value,
    input  logic [SW-1:0]           i_force_substep,
    input  logic                    i_step_trigger,
    input  logic                    i_step_polarity_rev,
    input  logic                    i_step_reverse,
    input  logic                    i_pwm_comp,
    input  logic                    i_bypass_power,
    input  logic [SW-1:0]           i_power,
    input  logic [K_DEADTIME_W-1:0] i_deadtime,
    output logic [5:0]              o_pattern,
    output logic [2:0]              o_step,
    output logic [SW-1:0]           o_substep,
    output logic                    o_commutate
);

    localparam logic [SW-1:0] SUB_MAX = SW'(K_NSUBSTEPS - 1);

    mode_e         mode;
    logic [2:0]    step_q;
    logic [2:0]    step_d;
    logic [SW-1:0] sub_q;
    logic [SW-1:0] sub_d;
    logic          comm_d;
    logic          comm_q;
    logic          inc;
    logic          at_edge;
    logic [2:0]    drive_idx;
    pattern_t      lut;
    logic [2:0]    hi;
    logic [2:0]    lo;
    logic          power_on;
    pattern_t      req;

    assign mode    = mode_e'(i_mode);
    assign inc     = ~step_q[0] ^ i_step_polarity_rev;
    assign at_edge = inc ? (sub_q == SUB_MAX) : (sub_q == '0);

    always_comb begin
        step_d = step_q;
        sub_d  = sub_q;
        comm_d = 1'b0;
        if (i_force_step_trigger) begin
            step_d = (i_force_step_value < 3'd6) ? i_force_step_value : 3'd0;
            sub_d  = (i_force_substep > SUB_MAX) ? SUB_MAX : i_force_substep;
        end else if (i_step_trigger && mode != HOLD) begin
            if (at_edge) begin
                step_d = step_wrap(step_q, ~i_step_polarity_rev);
                comm_d = 1'b1;
            end else begin
                sub_d = inc ? sub_q + SW'(1) : sub_q - SW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_q <= 3'd5;
            sub_q  <= '0;
            comm_q <= 1'b0;
        end else begin
            step_q <= step_d;
            sub_q  <= sub_d;
            comm_q <= comm_d;
        end
    end

    assign drive_idx = step_wrap(step_q, ~i_step_reverse);
    assign lut       = STEP_LUT[drive_idx];
    assign power_on  = i_bypass_power | (i_power > sub_q);

    // Chop off-phase: high side drops, complementary mode closes the same leg's low side
    always_comb begin
        hi = lut[5:3];
        lo = lut[2:0];
        if (!power_on) begin
            if (i_pwm_comp) lo = lo | hi;
            hi = 3'b000;
        end
    end

    always_comb begin
        req = {hi, lo};
        case (mode)
            COAST:   req = '0;
            BRAKE:   req = BRAKE_PATTERN;
            default: req = {hi, lo};
        endcase
    end

`ifdef COMMUTATION_ENGINE_DEADTIME_EN
    leg_t leg_req [3];
    leg_t leg_app [3];

    for (genvar g = 0; g < 3; g++) begin : g_leg
        assign leg_req[g] = '{h: req[5-g], l: req[2-g]};

        deadtime_leg #(
            .K_DEADTIME_W (K_DEADTIME_W)
        ) u_leg (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_req      (leg_req[g]),
            .i_deadtime (i_deadtime),
            .o_leg      (leg_app[g])
        );
    end

    assign o_pattern = {leg_app[0].h, leg_app[1].h, leg_app[2].h,
                        leg_app[0].l, leg_app[1].l, leg_app[2].l};
`else
    pattern_t pat_q;
    logic     unused_deadtime;

    assign unused_deadtime = ^i_deadtime;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pat_q <= '0;
        else          pat_q <= req;
    end

    assign o_pattern = pat_q;
`endif

    assign o_step      = step_q;
    assign o_substep   = sub_q;
    assign o_commutate = comm_q;

endmodule

// File: tb/tb_commutation_engine.sv
// tb_commutation_engine: directed self-checking bench for commutation_engine.
// Expected values are hand-derived from the step/LUT/chop/dead-time rules.
module tb_commutation_engine;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          force_trig;
    logic [2:0]    force_val;
    logic [SW-1:0] force_sub;
    logic          trig;
    logic          pol;
    logic          srev;
    logic          comp;
    logic          bypass;
    logic [SW-1:0] power;
    logic [3:0]    deadtime;
    logic [5:0]    pattern;
    logic [2:0]    step;
    logic [SW-1:0] substep;
    logic          commutate;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commutation_engine dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_mode               (mode),
        .i_force_step_trigger (force_trig),
        .i_force_step_value   (force_val),
        .i_force_substep      (force_sub),
        .i_step_trigger       (trig),
        .i_step_polarity_rev  (pol),
        .i_step_reverse       (srev),
        .i_pwm_comp           (comp),
        .i_bypass_power       (bypass),
        .i_power              (power),
        .i_deadtime           (deadtime),
        .o_pattern            (pattern),
        .o_step               (step),
        .o_substep            (substep),
        .o_commutate          (commutate)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic force_step(input logic [2:0] v, input logic [SW-1:0] s);
        force_val  = v;
        force_sub  = s;
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 2'd1;
        force_trig = 1'b0;
        force_val  = '0;
        force_sub  = '0;
        trig       = 1'b0;
        pol        = 1'b0;
        srev       = 1'b0;
        comp       = 1'b0;
        bypass     = 1'b0;
        power      = 4'd10;
        deadtime   = 4'd3;
        @(negedge clk);
        tick(2);
        chk("rst_pattern", pattern, 6'b000000);
        chk("rst_step", step, 3'd5);
        chk("rst_substep", substep, 0);
        chk("rst_comm", commutate, 0);
        rst_n = 1'b1;

        // step 5 forward drives index 0: CH.BL
`ifdef COMMUTATION_ENGINE_DEADTIME_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_dead_off", pattern, 6'b000000);
        end
`endif
        tick();
        chk("rst_first_on", pattern, 6'b001010);

        // forward step advance at top sub-step
        force_step(3'd0, 4'd8);
        chk("fwd_force_step", step, 0);
        chk("fwd_force_sub", substep, 8);
        chk("fwd_force_nocomm", commutate, 0);
        trig = 1'b1;
        tick();
        chk("fwd_sub9", substep, 9);
        chk("fwd_step0", step, 0);
        tick();
        trig = 1'b0;
        chk("fwd_step1", step, 1);
        chk("fwd_sub_hold", substep, 9);
        chk("fwd_comm_pulse", commutate, 1);
        tick();
        chk("fwd_comm_end", commutate, 0);

        // odd step forward counts sub-step down
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("dec_sub8", substep, 8);
        chk("dec_step1", step, 1);

        // reverse polarity wraps 0 -> 5
        pol = 1'b1;
        force_step(3'd0, 4'd0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("rev_wrap_step", step, 5);
        chk("rev_wrap_sub", substep, 0);
        chk("rev_wrap_comm", commutate, 1);
        pol = 1'b0;

        // complementary chop on AH.BL
        comp     = 1'b1;
        deadtime = 4'd2;
        force_step(3'd0, 4'd5);
        tick(6);
        chk("comp_on", pattern, 6'b100010);
        power = 4'd4;
`ifdef COMMUTATION_ENGINE_DEADTIME_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("comp_dead", pattern, 6'b000010);
            chk("comp_shoot", pattern[5:3] & pattern[2:0], 0);
        end
`endif
        tick();
        chk("comp_low_on", pattern, 6'b000110);
        chk("comp_shoot_end", pattern[5:3] & pattern[2:0], 0);

        // brake and coast
        mode = 2'd2;
        tick(6);
        chk("brake", pattern, 6'b000111);
        mode = 2'd0;
        tick();
        chk("coast", pattern, 6'b000000);

        // hold ignores triggers, force still loads
        mode  = 2'd3;
        comp  = 1'b0;
        power = 4'd10;
        force_step(3'd2, 4'd3);
        trig = 1'b1;
        tick(5);
        trig = 1'b0;
        chk("hold_step", step, 2);
        chk("hold_sub", substep, 3);
        chk("hold_nocomm", commutate, 0);
        tick(6);
        chk("hold_pattern", pattern, 6'b010001);
        force_step(3'd7, 4'd12);
        chk("force_oor_step", step, 0);
        chk("force_clamp_sub", substep, 9);

        // zero dead time: exact one-cycle path
        mode     = 2'd1;
        deadtime = 4'd0;
        tick(6);
        chk("dt0_base", pattern, 6'b100010);
        srev = 1'b1;
        tick();
        chk("dt0_reverse", pattern, 6'b001100);
        power = 4'd2;
        tick();
        chk("dt0_chop", pattern, 6'b000100);
        bypass = 1'b1;
        tick();
        chk("dt0_bypass", pattern, 6'b001100);

        // asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pattern", pattern, 6'b000000);
        chk("async_rst_step", step, 3'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
